booth_mult_scheduler: RTL and testbench

//   Shares one combinational 32x32 signed boothMultiplier instance between N_REQ requesters.

---
 rtl/booth_mult_scheduler.sv | 150 +++++++++++++++
 tb/tb_booth_mult_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_scheduler.sv
// Round-robin scheduler sharing one combinational radix-4 Booth 32x32 signed multiplier
// among N_REQ requesters; the array is a multicycle path sampled after SETTLE_CYCLES clocks.
module booth_mult_scheduler #(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned SETTLE_CYCLES = 5,
    localparam int unsigned ID_W         = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_x,
    input  logic [32*N_REQ-1:0]   req_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [63:0]           rsp_product,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       reg_x_q, reg_x_d;
    logic [31:0]       reg_y_q, reg_y_d;
    logic [63:0]       rsp_product_q, rsp_product_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [63:0]       product;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = (int'(last_grant_q) + 1 + k) % int'(N_REQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    assign req_ready = (state_q == StIdle && grant_found)
                     ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

    // Radix-4 Booth: y is scanned in overlapping 3-bit groups with an implicit 0 below bit 0.
    always_comb begin
        logic [63:0] xe;
        logic [63:0] pp;
        logic [32:0] yext;
        logic [2:0]  grp;
        xe      = {{32{reg_x_q[31]}}, reg_x_q};
        yext    = {reg_y_q, 1'b0};
        product = '0;
        pp      = '0;
        grp     = '0;
        for (int i = 0; i < 16; i++) begin
            grp = yext[2*i+2 -: 3];
            unique case (grp)
                3'b001, 3'b010: pp = xe;
                3'b011:         pp = xe << 1;
                3'b100:         pp = -(xe << 1);
                3'b101, 3'b110: pp = -xe;
                default:        pp = '0;
            endcase
            product = product + (pp << (2 * i));
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        reg_x_d       = reg_x_q;
        reg_y_d       = reg_y_q;
        rsp_product_d = rsp_product_q;
        rsp_id_d      = rsp_id_q;
        rsp_valid_d   = rsp_valid_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    reg_x_d      = req_x[32*grant_idx +: 32];
                    reg_y_d      = req_y[32*grant_idx +: 32];
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    cnt_d        = '0;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    rsp_product_d = product;
                    rsp_id_d      = id_q;
                    rsp_valid_d   = 1'b1;
                    state_d       = StDone;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            last_grant_q  <= ID_W'(N_REQ - 1);
            id_q          <= '0;
            reg_x_q       <= '0;
            reg_y_q       <= '0;
            rsp_product_q <= '0;
            rsp_id_q      <= '0;
            rsp_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            id_q          <= id_d;
            reg_x_q       <= reg_x_d;
            reg_y_q       <= reg_y_d;
            rsp_product_q <= rsp_product_d;
            rsp_id_q      <= rsp_id_d;
            rsp_valid_q   <= rsp_valid_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = rsp_product_q;
    assign rsp_id      = rsp_id_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Directed bench for booth_mult_scheduler: a 4-requester/5-cycle instance and a
// 2-requester/1-cycle instance, checked against hand-computed products and timing.
module tb_booth_mult_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_x = '0;
    logic [127:0] req_y = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [63:0]  rsp_product;
    logic [1:0]   rsp_id;
    logic         busy;

    logic         rst1 = 1'b1;
    logic [1:0]   req_valid1 = '0;
    logic [1:0]   req_ready1;
    logic [63:0]  req_x1 = '0;
    logic [63:0]  req_y1 = '0;
    logic         rsp_valid1;
    logic [63:0]  rsp_product1;
    logic [0:0]   rsp_id1;
    logic         busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_mult_scheduler #(.N_REQ(4), .SETTLE_CYCLES(5)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_product(rsp_product),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    booth_mult_scheduler #(.N_REQ(2), .SETTLE_CYCLES(1)) u_dut_fast (
        .clk        (clk),
        .rst        (rst1),
        .req_valid  (req_valid1),
        .req_ready  (req_ready1),
        .req_x      (req_x1),
        .req_y      (req_y1),
        .rsp_valid  (rsp_valid1),
        .rsp_ready  (1'b1),
        .rsp_product(rsp_product1),
        .rsp_id     (rsp_id1),
        .busy       (busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the main instance and wait for its response (no handshake).
    task automatic run_one(input string tag, input logic [3:0] vmask, input int idx,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [63:0] exp, input int exp_wait);
        int n;
        req_x[32*idx +: 32] = x;
        req_y[32*idx +: 32] = y;
        req_valid = vmask;
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_grant_wait"}, 64'(n), 64'(exp_wait));
        check({tag, "_grant"}, 64'(req_ready), 64'(4'b0001 << idx));
        tick();
        req_valid = '0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rsp_valid && n < 30);
        check({tag, "_latency"}, 64'(n), 64'd5);
        check({tag, "_product"}, rsp_product, exp);
        check({tag, "_id"}, 64'(rsp_id), 64'(idx));
    endtask

    logic [63:0] exp_prod [4];
    int          order [5];
    int          g, r, last_cyc, stable_err, n;

    initial begin
        // Reset state
        #2;
        check("rst_ctrl", {59'd0, busy, rsp_valid, req_ready[2:0] | {2'b0, req_ready[3]}},
              64'd0);
        check("rst_product", rsp_product, 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        tick();
        rst  = 1'b0;
        rst1 = 1'b0;
        tick();

        // 1: single request, -3 * 7
        rsp_ready = 1'b1;
        run_one("t1", 4'b0001, 0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        tick();
        check("t1_hs_valid", 64'(rsp_valid), 64'd0);
        check("t1_hs_busy", 64'(busy), 64'd0);

        // 2: extreme operands
        run_one("t2a", 4'b0100, 2, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
        tick();
        run_one("t2b", 4'b0100, 2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 0);
        tick();

        // 3: all requesters pending from reset -> order 0,1,2,3,0 spaced 7 clocks
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req_x = {32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000, 32'd5};
        req_y = {32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFF7};
        exp_prod[0] = 64'hFFFF_FFFF_FFFF_FFD3;
        exp_prod[1] = 64'h0000_0001_0000_0000;
        exp_prod[2] = 64'h0000_0000_0000_0001;
        exp_prod[3] = 64'h3FFF_FFFF_0000_0001;
        order = '{0, 1, 2, 3, 0};
        req_valid = 4'b1111;
        #1;
        g = 0;
        r = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 60 && r < 5; cyc++) begin
            if (req_ready != 4'b0 && g < 5) begin
                check("t3_grant", 64'(req_ready), 64'(4'b0001 << order[g]));
                if (g > 0) check("t3_spacing", 64'(cyc - last_cyc), 64'd7);
                last_cyc = cyc;
                g++;
            end
            if (rsp_valid && r < 5) begin
                check("t3_id", 64'(rsp_id), 64'(order[r]));
                check("t3_product", rsp_product, exp_prod[order[r]]);
                r++;
            end
            if (r == 5) req_valid = '0;
            else tick();
        end
        check("t3_count", 64'(r), 64'd5);
        tick();

        // 4: back-pressure in DONE
        rsp_ready = 1'b0;
        run_one("t4", 4'b0010, 1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 0);
        req_valid = 4'b0001;
        stable_err = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_product !== 64'hFFFF_FFFF_FFFF_FFFA ||
                rsp_id !== 2'd1 || busy !== 1'b1 || req_ready !== 4'b0)
                stable_err++;
        end
        check("t4_hold_stable", 64'(stable_err), 64'd0);
        rsp_ready = 1'b1;
        req_valid = '0;
        tick();
        check("t4_release_valid", 64'(rsp_valid), 64'd0);
        check("t4_product_held", rsp_product, 64'hFFFF_FFFF_FFFF_FFFA);
        tick();

        // 5: reset mid-BUSY
        req_x[127:96] = 32'd9;
        req_y[127:96] = 32'd9;
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        tick();
        check("t5_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_ctrl", {60'd0, busy, rsp_valid, req_ready[1:0] | req_ready[3:2]}, 64'd0);
        check("t5_rst_product", rsp_product, 64'd0);
        check("t5_rst_id", 64'(rsp_id), 64'd0);
        tick();
        rst = 1'b0;
        run_one("t5", 4'b1001, 0, 32'd6, 32'd7, 64'd42, 0);
        tick();

        // 6: single-cycle settle instance, 12345 * -6789
        req_x1[31:0] = 32'd12345;
        req_y1[31:0] = 32'hFFFF_E57B;
        req_valid1 = 2'b01;
        #1;
        check("t6_grant", 64'(req_ready1), 64'd1);
        tick();
        req_valid1 = '0;
        check("t6_no_early_valid", 64'(rsp_valid1), 64'd0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rsp_valid1 && n < 10);
        check("t6_latency", 64'(n), 64'd1);
        check("t6_product", rsp_product1, 64'hFFFF_FFFF_FB01_2863);
        check("t6_id", 64'(rsp_id1), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
